serdesphy_rx_deserializer: RTL and testbench
============================================

Name: serdesphy_rx_deserializer

Overview:
Receive-path stage directly upstream of the Manchester decoder. It takes the recovered serial chip stream from the CDR, finds word alignment by hunting for a sync pattern, and assembles 16-chip words. It emits each word as manchester_data with a one-cycle data_valid pulse, which is the decoder's input handshake. It also tracks lock and drops lock on repeated malformed words.

Parameters:
SYNC_PATTERN, 16'hFF00, alignment word; contains illegal Manchester pairs, so it never occurs in valid data at any alignment.
MAX_BAD_WORDS, 3, consecutive malformed words that force loss of lock (legal range 1..15).

Ports:
clk  input  1  24 MHz clock
rst_n  input  1  asynchronous active-low reset
rx_en  input  1  receiver enable; low forces HUNT
rx_chip  input  1  recovered chip value
rx_chip_valid  input  1  rx_chip strobe, at most one per 2 clk cycles
manchester_data  output  16  aligned word; first-received chip in bit 15
data_valid  output  1  one-cycle pulse, word valid
locked  output  1  high while in LOCKED
sync_detect  output  1  one-cycle pulse on every sync match (initial lock or re-sync)
lock_lost  output  1  one-cycle pulse when LOCKED->HUNT due to bad words
bad_word_count  output  8  present only with SERDESPHY_DESER_STATS_EN

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = HUNT.
  - Shift register, chip counter, bad-word counter = 0.
  - manchester_data = 16'h0000.
  - data_valid, locked, sync_detect, lock_lost = 0.
- Shift register (shreg): on each rx_chip_valid, shreg <= {shreg[14:0], rx_chip}. Without rx_chip_valid it holds.
- Pair i = {shreg[2i+1], shreg[2i]}. 2'b00 and 2'b11 are invalid. A word is malformed if any of its 8 pairs is invalid.
- State HUNT:
  - Every accepted chip is compared against SYNC_PATTERN using the updated window (the value shreg takes after the shift).
  - On a match: go to LOCKED, chip counter = 0, bad-word counter = 0, sync_detect pulses the cycle after the chip strobe.
  - No data_valid is ever issued in HUNT.
- State LOCKED:
  - locked = 1.
  - The chip counter (4-bit) increments per accepted chip and wraps 15 -> 0. The 16th chip completes a word.
  - At word completion, the completed word equals SYNC_PATTERN: re-sync. sync_detect pulses, no data_valid, counter stays aligned, bad-word counter = 0.
  - At word completion, word is well-formed: manchester_data <= word, data_valid pulses one cycle (registered, 1 clk after the 16th chip strobe), bad-word counter = 0.
  - At word completion, word is malformed: the word is still output with data_valid (the decoder flags the error). The bad-word counter then increments.
  - If the incremented bad-word count reaches MAX_BAD_WORDS: go to HUNT, locked falls in the same cycle as data_valid, lock_lost pulses, counters clear.
- manchester_data holds its last value between pulses; downstream samples only on data_valid.
- With the strobe-rate limit, data_valid pulses are at least 32 clk apart, which covers the decoder's 4-cycle accept loop.
- rx_en low:
  - Synchronous return to HUNT next cycle, counters clear, locked = 0.
  - No lock_lost pulse. Any pending data_valid is suppressed.
  - shreg keeps shifting, so a hunt can begin immediately when rx_en rises.
- rx_chip_valid while rx_en is low: the shift still happens, but no match is acted on.
- Reset mid-word discards the partial word. No pulse is emitted after reset release until a new sync match.
- Output pulses (data_valid, sync_detect, lock_lost) are all registered and never wider than one cycle.

Optional Feature:
SERDESPHY_DESER_STATS_EN
- Defined: adds output bad_word_count[7:0], a saturating count (sticks at 255) of malformed words seen while LOCKED. It is cleared only by rst_n and is not cleared by re-sync, lock loss or rx_en.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. rx_en=1; feed random valid-Manchester chips, then 16'hFF00 MSB-first -> no data_valid before sync; sync_detect and locked=1 one clk after the last sync chip.
2. After lock, send byte 8'hA5 encoded MSB-first (0=10, 1=01): chips 0110_0110_1001_1001 -> data_valid once with manchester_data=16'h6699.
3. After lock, send 3 words of 16'h0000 with defaults -> three data_valid pulses; on the third, lock_lost pulses and locked=0; the next valid word produces no data_valid.
4. Two malformed words, then one valid word, then two malformed words -> lock is held throughout (counter reset by the valid word); stats build shows bad_word_count=4.
5. While locked, send SYNC_PATTERN at a word boundary -> sync_detect pulse, no data_valid; the following word decodes normally. Drop rx_en mid-word -> locked=0 next clk, no lock_lost, no data_valid.
6. Assert rst_n low for one cycle mid-word while locked -> all outputs 0 immediately; a partial word is never emitted; re-lock requires a fresh SYNC_PATTERN.

Source files
------------

// File: rtl/serdesphy_rx_deserializer_if.sv
// Word handshake from the RX deserializer to the Manchester decoder:
// an aligned 16-chip word qualified by a one-cycle data_valid pulse.
interface serdesphy_rx_deserializer_if;
    logic [15:0] manchester_data;
    logic        data_valid;

    modport master (
        output manchester_data,
        output data_valid
    );

    modport slave (
        input manchester_data,
        input data_valid
    );
endinterface

// File: rtl/serdesphy_rx_deserializer.sv
// RX deserializer: hunts for SYNC_PATTERN, assembles 16-chip words and tracks lock.
// Define SERDESPHY_DESER_STATS_EN to add the saturating bad_word_count output.
module serdesphy_rx_deserializer #(
    parameter logic [15:0] SYNC_PATTERN  = 16'hFF00,
    parameter int          MAX_BAD_WORDS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_en,
    input  logic rx_chip,
    input  logic rx_chip_valid,
    serdesphy_rx_deserializer_if.master word_if,
    output logic locked,
    output logic sync_detect,
    output logic lock_lost
`ifdef SERDESPHY_DESER_STATS_EN
    ,
    output logic [7:0] bad_word_count
`endif
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam logic [3:0] MAX_BAD = 4'(MAX_BAD_WORDS);

    state_t      state;
    logic [15:0] shreg;
    logic [15:0] shreg_next;
    logic [3:0]  chip_cnt;
    logic [3:0]  bad_cnt;
    logic        word_end;
    logic        word_is_sync;
    logic        word_bad;
    logic        bad_event;

    // A Manchester symbol must be a transition; a repeated chip in any pair is illegal.
    function automatic logic is_malformed(input logic [15:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w[2*i+1] == w[2*i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    always_comb begin
        shreg_next   = rx_chip_valid ? {shreg[14:0], rx_chip} : shreg;
        word_end     = rx_en && rx_chip_valid && (state == LOCKED) && (chip_cnt == 4'd15);
        word_is_sync = (shreg_next == SYNC_PATTERN);
        word_bad     = is_malformed(shreg_next);
        bad_event    = word_end && !word_is_sync && word_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= HUNT;
            shreg                   <= 16'h0000;
            chip_cnt                <= 4'd0;
            bad_cnt                 <= 4'd0;
            word_if.manchester_data <= 16'h0000;
            word_if.data_valid      <= 1'b0;
            locked                  <= 1'b0;
            sync_detect             <= 1'b0;
            lock_lost               <= 1'b0;
        end else begin
            word_if.data_valid <= 1'b0;
            sync_detect        <= 1'b0;
            lock_lost          <= 1'b0;
            if (rx_chip_valid) begin
                shreg <= shreg_next;
            end
            // Disabling the receiver abandons alignment but keeps the window filling.
            if (!rx_en) begin
                state    <= HUNT;
                locked   <= 1'b0;
                chip_cnt <= 4'd0;
                bad_cnt  <= 4'd0;
            end else if (rx_chip_valid) begin
                case (state)
                    HUNT: begin
                        if (word_is_sync) begin
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            chip_cnt    <= 4'd0;
                            bad_cnt     <= 4'd0;
                            sync_detect <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        chip_cnt <= chip_cnt + 4'd1;
                        if (word_end) begin
                            if (word_is_sync) begin
                                sync_detect <= 1'b1;
                                bad_cnt     <= 4'd0;
                            end else begin
                                word_if.manchester_data <= shreg_next;
                                word_if.data_valid      <= 1'b1;
                                // Malformed words still go out; the decoder flags them.
                                if (!word_bad) begin
                                    bad_cnt <= 4'd0;
                                end else if (bad_cnt + 4'd1 == MAX_BAD) begin
                                    state     <= HUNT;
                                    locked    <= 1'b0;
                                    lock_lost <= 1'b1;
                                    chip_cnt  <= 4'd0;
                                    bad_cnt   <= 4'd0;
                                end else begin
                                    bad_cnt <= bad_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef SERDESPHY_DESER_STATS_EN
    // Lifetime statistic; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_word_count <= 8'd0;
        end else if (bad_event && (bad_word_count != 8'hFF)) begin
            bad_word_count <= bad_word_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serdesphy_rx_deserializer.sv
// Scoreboard bench for serdesphy_rx_deserializer: a chip-level reference model
// queues expected pulses, and a monitor checks them as the DUT emits them.
module tb_serdesphy_rx_deserializer;

    localparam logic [15:0] SYNC    = 16'hFF00;
    localparam int          MAX_BAD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b0;
    logic rx_chip = 1'b0;
    logic rx_chip_valid = 1'b0;
    logic locked;
    logic sync_detect;
    logic lock_lost;
`ifdef SERDESPHY_DESER_STATS_EN
    logic [7:0] bad_word_count;
`endif

    serdesphy_rx_deserializer_if word_if ();

    serdesphy_rx_deserializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_en         (rx_en),
        .rx_chip       (rx_chip),
        .rx_chip_valid (rx_chip_valid),
        .word_if       (word_if),
        .locked        (locked),
        .sync_detect   (sync_detect),
        .lock_lost     (lock_lost)
`ifdef SERDESPHY_DESER_STATS_EN
        ,
        .bad_word_count(bad_word_count)
`endif
    );

    always #21 clk = ~clk;

    typedef struct packed {
        logic        dv;
        logic        sd;
        logic        ll;
        logic        lk;
        logic [15:0] word;
    } event_t;

    event_t expQ[$];
    int     assertCount = 0;
    int     failCount = 0;

    // Reference model state: recent chip history and the chips of the word being built.
    bit     chipHist[$];
    bit     wordChips[$];
    bit     mLocked = 1'b0;
    int     mBad = 0;
    int     mStats = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] lastWindow();
        logic [15:0] w;
        w = 16'h0000;
        foreach (chipHist[i]) w = {w[14:0], chipHist[i]};
        return w;
    endfunction

    // Chronological chip pairs; a legal symbol is "10" or "01".
    function automatic bit wordMalformed(input logic [15:0] w);
        for (int p = 0; p < 8; p++) begin
            if (w[15-2*p] == w[14-2*p]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] encodeByte(input logic [7:0] d);
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 7; i >= 0; i--) w = {w[13:0], (d[i] ? 2'b01 : 2'b10)};
        return w;
    endfunction

    function automatic logic [15:0] badWord();
        logic [15:0] w;
        int p;
        w = encodeByte(8'($urandom));
        p = $urandom_range(0, 7);
        w[2*p +: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        return w;
    endfunction

    task automatic pushEvent(input logic dv, input logic sd, input logic ll, input logic lk, input logic [15:0] w);
        event_t e;
        e.dv = dv;
        e.sd = sd;
        e.ll = ll;
        e.lk = lk;
        e.word = w;
        expQ.push_back(e);
    endtask

    task automatic modelChip(input bit b);
        logic [15:0] w;
        chipHist.push_back(b);
        if (chipHist.size() > 16) void'(chipHist.pop_front());
        if (!rx_en) return;
        if (!mLocked) begin
            if (lastWindow() == SYNC) begin
                mLocked = 1'b1;
                mBad = 0;
                wordChips.delete();
                pushEvent(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
            end
        end else begin
            wordChips.push_back(b);
            if (wordChips.size() == 16) begin
                w = 16'h0000;
                foreach (wordChips[i]) w = {w[14:0], wordChips[i]};
                wordChips.delete();
                if (w == SYNC) begin
                    mBad = 0;
                    pushEvent(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
                end else if (wordMalformed(w)) begin
                    mBad++;
                    if (mStats < 255) mStats++;
                    if (mBad == MAX_BAD) begin
                        mLocked = 1'b0;
                        mBad = 0;
                        pushEvent(1'b1, 1'b0, 1'b1, 1'b0, w);
                    end else begin
                        pushEvent(1'b1, 1'b0, 1'b0, 1'b1, w);
                    end
                end else begin
                    mBad = 0;
                    pushEvent(1'b1, 1'b0, 1'b0, 1'b1, w);
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit b);
        @(negedge clk);
        rx_chip = b;
        rx_chip_valid = 1'b1;
        modelChip(b);
        @(negedge clk);
        rx_chip_valid = 1'b0;
        rx_chip = 1'($urandom);
        checkOutput("locked", 32'(locked), 32'(mLocked));
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic sendWord(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) applyStimulus(w[i]);
    endtask

    task automatic sendRandomValid(input int n);
        repeat (n) sendWord(encodeByte(8'($urandom)));
    endtask

    task automatic dropRxEn();
        @(negedge clk);
        rx_en = 1'b0;
        mLocked = 1'b0;
        mBad = 0;
        wordChips.delete();
        @(negedge clk);
        checkOutput("locked_after_rx_en_low", 32'(locked), 32'd0);
        @(negedge clk);
        rx_en = 1'b1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_data_valid", 32'(word_if.data_valid), 32'd0);
        checkOutput("reset_sync_detect", 32'(sync_detect), 32'd0);
        checkOutput("reset_lock_lost", 32'(lock_lost), 32'd0);
        checkOutput("reset_manchester_data", 32'(word_if.manchester_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mLocked = 1'b0;
        mBad = 0;
        mStats = 0;
        chipHist.delete();
        wordChips.delete();
    endtask

    // Monitor: every DUT pulse must match the oldest expected event.
    always @(negedge clk) begin
        event_t e;
        if (rst_n && (word_if.data_valid || sync_detect || lock_lost)) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_pulse: got dv=%0b sd=%0b ll=%0b, expected none at %0t",
                         word_if.data_valid, sync_detect, lock_lost, $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse_flags", 32'({word_if.data_valid, sync_detect, lock_lost}),
                            32'({e.dv, e.sd, e.ll}));
                checkOutput("locked_at_pulse", 32'(locked), 32'(e.lk));
                if (e.dv) checkOutput("manchester_data", 32'(word_if.manchester_data), 32'(e.word));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_data_valid", 32'(word_if.data_valid), 32'd0);
        checkOutput("reset_manchester_data", 32'(word_if.manchester_data), 32'd0);
        rst_n = 1'b1;
        rx_en = 1'b1;

        // Acquire lock from a stream of legal data at an arbitrary chip offset.
        sendRandomValid(2);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        sendWord(SYNC);
        sendWord(encodeByte(8'hA5));
        sendRandomValid(3);

        // Three consecutive malformed words lose lock; the next word is ignored.
        repeat (3) sendWord(16'h0000);
        sendRandomValid(1);

        // A good word in between keeps the bad-word run from reaching the limit.
        sendWord(SYNC);
        sendWord(badWord());
        sendWord(badWord());
        sendRandomValid(1);
        sendWord(badWord());
        sendWord(badWord());
        sendRandomValid(1);

        // Re-sync at a word boundary, then drop the enable mid-word.
        sendWord(SYNC);
        sendRandomValid(1);
        for (int i = 0; i < 7; i++) applyStimulus(1'($urandom));
        dropRxEn();
        for (int i = 0; i < 9; i++) applyStimulus(1'($urandom));
        sendWord(SYNC);
        sendRandomValid(1);

        // Randomized mix of legal, malformed, sync and misaligning traffic.
        for (int n = 0; n < 30; n++) begin
            int r;
            r = $urandom_range(0, 10);
            if (r <= 5) sendRandomValid(1);
            else if (r <= 7) sendWord(badWord());
            else if (r == 8) sendWord(SYNC);
            else if (r == 9) repeat ($urandom_range(1, 3)) applyStimulus(1'($urandom));
            else dropRxEn();
        end

        // Reset mid-word while locked: partial word discarded, re-lock needs sync.
        dropRxEn();
        sendWord(SYNC);
        sendRandomValid(1);
        for (int i = 0; i < 8; i++) applyStimulus(1'($urandom));
        pulseReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'($urandom));
        sendRandomValid(2);
        sendWord(SYNC);
        sendRandomValid(1);
        sendWord(badWord());

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
`ifdef SERDESPHY_DESER_STATS_EN
        checkOutput("bad_word_count", 32'(bad_word_count), 32'(mStats));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
